// File: rtl/xy_acc_mover_if.sv
// Request/response bundle between the control unit and xy_acc_mover.
// The slave modport is the mover's view, the master modport the requester's view.
interface xy_acc_mover_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic             req_sel_xy;
    logic [WIDTH-1:0] acc_in;
    logic             acc_we;
    logic [WIDTH-1:0] acc_wdata;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] x_out;
    logic [WIDTH-1:0] y_out;

    modport slave (
        input  req_valid, req_op, req_sel_xy, acc_in,
        output req_ready, acc_we, acc_wdata, done, err, x_out, y_out
    );

    modport master (
        output req_valid, req_op, req_sel_xy, acc_in,
        input  req_ready, acc_we, acc_wdata, done, err, x_out, y_out
    );
endinterface

// File: rtl/xy_acc_mover.sv
// xy_acc_mover: owns the X/Y registers and moves data between them and the
// accumulator on a valid/ready request.
//   op 00 MOV ACC,reg  op 01 MOV reg,ACC  op 10 XCHG ACC,reg  op 11 illegal
// Optional feature macro: XY_XCHG_EN builds the XCHG path (SWAP2 state).
// Without it op 10 completes as an illegal op.
// All outputs come straight from registers; the pulse outputs are loaded on
// the edge that enters the cycle in which they must be visible.
module xy_acc_mover #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    xy_acc_mover_if.slave  bus
);

    localparam logic [1:0] OP_MOV_ACC = 2'b00;
    localparam logic [1:0] OP_MOV_REG = 2'b01;
`ifdef XY_XCHG_EN
    localparam logic [1:0] OP_XCHG    = 2'b10;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef XY_XCHG_EN
        ST_SWAP2 = 2'd2,
`endif
        ST_EXEC  = 2'd1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    // Request fields captured at accept
    logic [1:0]       op_r,     op_nxt_s;
    logic             sel_r,    sel_nxt_s;
    logic [WIDTH-1:0] acc_r,    acc_nxt_s;

    logic [WIDTH-1:0] x_r,      x_nxt_s;
    logic [WIDTH-1:0] y_r,      y_nxt_s;

    // Output registers; in the XCHG path wdata_r doubles as the swap
    // temporary, holding the old register value through SWAP2.
    logic             ready_r,  ready_nxt_s;
    logic             we_r,     we_nxt_s;
    logic             done_r,   done_nxt_s;
    logic             err_r,    err_nxt_s;
    logic [WIDTH-1:0] wdata_r,  wdata_nxt_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, register updates and next output values
    always_comb begin
        state_nxt_s = state_r;
        op_nxt_s    = op_r;
        sel_nxt_s   = sel_r;
        acc_nxt_s   = acc_r;
        x_nxt_s     = x_r;
        y_nxt_s     = y_r;
        we_nxt_s    = 1'b0;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        wdata_nxt_s = wdata_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_nxt_s = ST_EXEC;
                    op_nxt_s    = bus.req_op;
                    sel_nxt_s   = bus.req_sel_xy;
                    acc_nxt_s   = bus.acc_in;
                    case (bus.req_op)
                        OP_MOV_ACC: begin
                            we_nxt_s    = 1'b1;
                            done_nxt_s  = 1'b1;
                            wdata_nxt_s = bus.req_sel_xy ? y_r : x_r;
                        end
                        OP_MOV_REG: begin
                            done_nxt_s = 1'b1;
                        end
`ifdef XY_XCHG_EN
                        OP_XCHG: begin
                            // completion is signalled from SWAP2
                            done_nxt_s = 1'b0;
                        end
`endif
                        default: begin
                            done_nxt_s = 1'b1;
                            err_nxt_s  = 1'b1;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_IDLE;
                case (op_r)
                    OP_MOV_REG: begin
                        if (sel_r) begin
                            y_nxt_s = acc_r;
                        end else begin
                            x_nxt_s = acc_r;
                        end
                    end
`ifdef XY_XCHG_EN
                    OP_XCHG: begin
                        state_nxt_s = ST_SWAP2;
                        we_nxt_s    = 1'b1;
                        done_nxt_s  = 1'b1;
                        wdata_nxt_s = sel_r ? y_r : x_r;
                        if (sel_r) begin
                            y_nxt_s = acc_r;
                        end else begin
                            x_nxt_s = acc_r;
                        end
                    end
`endif
                    default: begin
                        state_nxt_s = ST_IDLE;
                    end
                endcase
            end
`ifdef XY_XCHG_EN
            ST_SWAP2: begin
                state_nxt_s = ST_IDLE;
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        ready_nxt_s = (state_nxt_s == ST_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r    <= 2'b00;
            sel_r   <= 1'b0;
            acc_r   <= {WIDTH{1'b0}};
            x_r     <= {WIDTH{1'b0}};
            y_r     <= {WIDTH{1'b0}};
            ready_r <= 1'b1;
            we_r    <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            wdata_r <= {WIDTH{1'b0}};
        end else begin
            op_r    <= op_nxt_s;
            sel_r   <= sel_nxt_s;
            acc_r   <= acc_nxt_s;
            x_r     <= x_nxt_s;
            y_r     <= y_nxt_s;
            ready_r <= ready_nxt_s;
            we_r    <= we_nxt_s;
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
            wdata_r <= wdata_nxt_s;
        end
    end

    assign bus.req_ready = ready_r;
    assign bus.acc_we    = we_r;
    assign bus.acc_wdata = wdata_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.x_out     = x_r;
    assign bus.y_out     = y_r;

endmodule
